// File: rtl/pwm_bank_if.sv
// PicoSoC iomem bus bundle used by pwm_bank.
// The master drives the request; the slave returns ready and read data.
interface pwm_bank_if;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_ready, iomem_rdata
    );

    modport slave (
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_ready, iomem_rdata
    );
endinterface

// File: rtl/pwm_bank.sv
// Multi-channel PWM bus slave: shared prescaler and period counter, N duty compares, wrap pulse.
// Define PWM_BANK_SHADOW_EN to load period/duty into the active copies only at wrap or while stopped.
module pwm_bank #(
    parameter int          CHANNELS  = 4,
    parameter int          WIDTH     = 16,
    parameter logic [23:0] BASE_ADDR = 24'h030005
) (
    input  logic                clk,
    input  logic                reset,
    pwm_bank_if.slave           bus,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                wrap_irq
);

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
        logic [31:0] r;
        r = 32'd0;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    logic                ready_q, ready_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                run_q, run_d;
    logic [CHANNELS-1:0] en_q, en_d;
    logic [WIDTH-1:0]    period_q, period_d;
    logic [15:0]         prescale_q, prescale_d;
    logic [WIDTH-1:0]    duty_q [CHANNELS];
    logic [WIDTH-1:0]    duty_d [CHANNELS];
    logic [15:0]         pre_q, pre_d;
    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic                wrap_q, wrap_d;

    logic [WIDTH-1:0]    period_act;
    logic [WIDTH-1:0]    duty_act [CHANNELS];

    logic [5:0]          word_s;
    logic                accept_s;
    logic                wr_en_s;
    logic [31:0]         rd_val_s;
    logic [31:0]         wr_val_s;
    logic                tick_s;
    logic                at_top_s;
    logic                wrap_s;
    logic                unused_bits_s;

    assign word_s   = bus.iomem_addr[7:2];
    assign accept_s = bus.iomem_valid && !ready_q && (bus.iomem_addr[31:8] == BASE_ADDR);
    assign wr_en_s  = accept_s && (bus.iomem_wstrb != 4'b0000);

    // Register file: read mux, byte-merged writes and the one-cycle acknowledge.
    always_comb begin
        rd_val_s = 32'd0;
        case (word_s)
            6'd0: begin
                rd_val_s[0]             = run_q;
                rd_val_s[8 +: CHANNELS] = en_q;
            end
            6'd1:    rd_val_s = zext(period_q);
            6'd2:    rd_val_s = {16'd0, prescale_q};
            6'd3:    rd_val_s = zext(cnt_q);
            default: begin
                for (int i = 0; i < CHANNELS; i++) begin
                    rd_val_s = (word_s == 6'(4 + i)) ? zext(duty_q[i]) : rd_val_s;
                end
            end
        endcase

        // The read mux already yields the current register value, so it is the merge base.
        wr_val_s   = merge_bytes(rd_val_s, bus.iomem_wdata, bus.iomem_wstrb);
        run_d      = run_q;
        en_d       = en_q;
        period_d   = period_q;
        prescale_d = prescale_q;
        duty_d     = duty_q;
        case (word_s)
            6'd0: begin
                run_d = wr_en_s ? wr_val_s[0] : run_q;
                en_d  = wr_en_s ? wr_val_s[8 +: CHANNELS] : en_q;
            end
            6'd1:    period_d   = wr_en_s ? wr_val_s[WIDTH-1:0] : period_q;
            6'd2:    prescale_d = wr_en_s ? wr_val_s[15:0] : prescale_q;
            default: begin
                for (int i = 0; i < CHANNELS; i++) begin
                    duty_d[i] = (wr_en_s && (word_s == 6'(4 + i))) ? wr_val_s[WIDTH-1:0] : duty_q[i];
                end
            end
        endcase

        ready_d = accept_s;
        rdata_d = (accept_s && !wr_en_s) ? rd_val_s : 32'd0;
    end

    // Prescaler, period counter, compare outputs and wrap pulse.
    always_comb begin
        tick_s   = (pre_q == prescale_q);
        // The all-ones term covers a counter that has overtaken a shortened period.
        at_top_s = (cnt_q == period_act) || (cnt_q == {WIDTH{1'b1}});
        wrap_s   = run_q && tick_s && at_top_s;

        pre_d = run_q ? (tick_s ? 16'd0 : pre_q + 16'd1) : 16'd0;
        cnt_d = run_q ? (tick_s ? (at_top_s ? {WIDTH{1'b0}} : cnt_q + WIDTH'(1)) : cnt_q)
                      : {WIDTH{1'b0}};

        for (int i = 0; i < CHANNELS; i++) begin
            pwm_d[i] = run_q && en_q[i] && (cnt_q < duty_act[i]);
        end
        wrap_d = wrap_s;
    end

`ifdef PWM_BANK_SHADOW_EN
    logic [WIDTH-1:0] period_act_q, period_act_d;
    logic [WIDTH-1:0] duty_act_q [CHANNELS];
    logic [WIDTH-1:0] duty_act_d [CHANNELS];
    logic             load_act_s;

    // Active copies track the bus registers while stopped and otherwise only at a wrap.
    always_comb begin
        load_act_s   = !run_q || wrap_s;
        period_act_d = load_act_s ? period_q : period_act_q;
        for (int i = 0; i < CHANNELS; i++) begin
            duty_act_d[i] = load_act_s ? duty_q[i] : duty_act_q[i];
            duty_act[i]   = duty_act_q[i];
        end
        period_act = period_act_q;
    end

    // Active-copy state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_act_q <= {WIDTH{1'b0}};
            for (int i = 0; i < CHANNELS; i++) begin
                duty_act_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            period_act_q <= period_act_d;
            duty_act_q   <= duty_act_d;
        end
    end
`else
    // Without shadowing the compare uses the bus registers directly.
    always_comb begin
        period_act = period_q;
        for (int i = 0; i < CHANNELS; i++) begin
            duty_act[i] = duty_q[i];
        end
    end
`endif

    // Bus, configuration and counting state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q    <= 1'b0;
            rdata_q    <= 32'd0;
            run_q      <= 1'b0;
            en_q       <= {CHANNELS{1'b0}};
            period_q   <= {WIDTH{1'b0}};
            prescale_q <= 16'd0;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_q[i] <= {WIDTH{1'b0}};
            end
            pre_q      <= 16'd0;
            cnt_q      <= {WIDTH{1'b0}};
            pwm_q      <= {CHANNELS{1'b0}};
            wrap_q     <= 1'b0;
        end else begin
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            run_q      <= run_d;
            en_q       <= en_d;
            period_q   <= period_d;
            prescale_q <= prescale_d;
            duty_q     <= duty_d;
            pre_q      <= pre_d;
            cnt_q      <= cnt_d;
            pwm_q      <= pwm_d;
            wrap_q     <= wrap_d;
        end
    end

    assign bus.iomem_ready = ready_q;
    assign bus.iomem_rdata = rdata_q;
    assign pwm_out         = pwm_q;
    assign wrap_irq        = wrap_q;
    assign unused_bits_s   = ^{bus.iomem_addr[1:0], wr_val_s};

endmodule

// File: doc/pwm_bank.md
# pwm_bank

Parametrised multi-channel PWM peripheral on the PicoSoC iomem bus. It replaces the per-channel `pwm` instances and their hand-decoded 32-bit duty registers with one bus slave. The slave has a shared prescaler and a period counter, N duty channels, a global run bit, per-channel enables, glitch-free shadowed duty/period updates, and a period-wrap interrupt pulse that can drive a spare `irq_*` line.

## Interface
- `CHANNELS`, 4: number of PWM outputs, 1..16.
- `WIDTH`, 16: counter, period and duty width, 2..32.
- `BASE_ADDR`, 24'h030005: slave responds when `iomem_addr[31:8] == BASE_ADDR`.
- `clk` in 1: system clock.
- `reset` in 1: one clock; reset is asynchronous and active-high.
- `iomem_valid` in 1: bus request.
- `iomem_ready` out 1: one-cycle acknowledge.
- `iomem_wstrb` in 4: byte write strobes; all zero means read.
- `iomem_addr` in 32: byte address.
- `iomem_wdata` in 32: write data.
- `iomem_rdata` out 32: read data, valid while `iomem_ready` is high.
- `pwm_out` out CHANNELS: PWM outputs.
- `wrap_irq` out 1: one-cycle pulse at each period wrap.

## Operation
- **Register map** (`iomem_addr[7:2]`, byte offsets):
  - 0x00 CTRL: bit0 RUN; bits [8+CHANNELS-1:8] EN.
  - 0x04 PERIOD: WIDTH bits.
  - 0x08 PRESCALE: 16 bits.
  - 0x0C COUNT: read-only.
  - 0x10+4·i DUTY[i]: WIDTH bits.
- **Bus writes:**
  - Byte strobes apply per byte.
  - Bits beyond a register's width are ignored.
  - Writes to COUNT or unmapped offsets are ignored.
- **Bus reads:**
  - Return the register value zero-extended.
  - PERIOD and DUTY reads return the written (shadow) value, not the active value.
  - Unmapped offsets read 0.
- **Prescaler:**
  - While RUN=1, `pre` counts 0..PRESCALE.
  - `tick` is asserted when `pre==PRESCALE`; `pre` then returns to 0.
  - PRESCALE=0 gives a tick every cycle.
- **Counter:**
  - On each tick, `cnt` increments.
  - When `cnt==period_act` on a tick, `cnt` goes to 0. This is the wrap event.
  - PERIOD=0 keeps `cnt` at 0 and wraps on every tick.
- **Output:** `pwm_out[i]` is registered and equals RUN & EN[i] & (`cnt < duty_act[i]`).
  - Duty 0 gives a constant low output.
  - Duty > period_act gives a constant high output.
  - Duty is never compared modulo the counter width.
- **Wrap pulse:** `wrap_irq` is registered; it is high for exactly one cycle, in the cycle after a wrap.
- **RUN=0:**
  - `pre` and `cnt` are held at 0; all `pwm_out` and `wrap_irq` are 0.
  - `period_act` and `duty_act` continuously copy the shadow registers.
- **RUN 0→1:** counting starts from `cnt=0` with the current shadow values.

## Timing
- **Reset values:** `iomem_ready`=0, `iomem_rdata`=0, `pwm_out`=0, `wrap_irq`=0. CTRL, PERIOD, PRESCALE, all DUTY, `pre`, `cnt` and all active copies are 0.
- **Handshake:**
  - A request is accepted when `iomem_valid && !iomem_ready` and the address matches.
  - `iomem_ready` rises the next cycle, for exactly one cycle.
  - `iomem_rdata` is loaded in the same edge as `iomem_ready` rises.
  - The block does not respond while `iomem_ready` is high, so back-to-back requests take 2 cycles each.
  - The write takes effect in the same edge as `iomem_ready` rises.
- **Output latency:** `pwm_out` lags the `cnt` compare by 1 cycle. A CTRL write that clears EN[i] forces `pwm_out[i]` low 1 cycle after `iomem_ready`.
- **Write at wrap:** a DUTY or PERIOD write in the same edge as a wrap is not transferred at that wrap. It takes effect at the following wrap.
- **Reset mid-period:** asynchronous reset clears all state immediately. An outstanding bus request gets no `iomem_ready`.

## Configuration
- `PWM_BANK_SHADOW_EN` defined:
  - `period_act` and `duty_act` load from the shadow registers only at wrap or while RUN=0.
  - Updates are glitch-free.
- Not defined:
  - `period_act`/`duty_act` are the bus registers directly, so a write affects the compare on the next cycle.
  - If `cnt` is already greater than the new PERIOD, it counts up to the WIDTH maximum and wraps there.

## Test plan
- **Reset defaults:** assert reset mid-run → all outputs 0 asynchronously; read CTRL, PERIOD, DUTY0 → 0, each with `iomem_ready` high for exactly 1 cycle.
- **Basic waveform:** PRESCALE=0, PERIOD=9, DUTY0=3, CTRL=0x101 → `pwm_out[0]` high 3 of every 10 cycles; `wrap_irq` pulses every 10 cycles.
- **Duty edge values:** DUTY1=0 → `pwm_out[1]` constant 0; DUTY1=10 with PERIOD=9 → constant 1; CTRL EN bit1 cleared → `pwm_out[1]` 0 after 1 cycle.
- **Shadow update (macro on):** DUTY0 changed 3→7 at `cnt`=5 → current period stays 3-high, next period 7-high. Macro off → output changes in the current period.
- **Prescaler and COUNT:** PRESCALE=3, PERIOD=4 → `cnt` advances every 4 cycles and wraps every 20 cycles; COUNT read returns the live `cnt`.
- **Bus decode:** byte write wstrb=4'b0001 of 0xFFFF_FFFF to DUTY0 → DUTY0=0x00FF; access with `iomem_addr[31:8]` ≠ BASE_ADDR → no `iomem_ready`; read of unmapped offset 0x3C → 0.
